// File: rtl/sync_edge_qualifier.sv
// Debounces a synchronized level: a change is accepted only after it has held for
// STABLE_CYCLES consecutive samples, then emits edge pulses and counts rising events.
module sync_edge_qualifier #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk_dest,
  input  logic             rst_n,
  input  logic             sync_in,
  input  logic             cnt_clr,
  output logic             level_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] event_cnt,
  output logic             cnt_sat
);

  typedef enum logic [1:0] {
    S_LOW,
    S_QUAL_H,
    S_HIGH,
    S_QUAL_L
  } state_e;

  localparam logic [7:0]       QualCnt = 8'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  logic [7:0]       stab_q, stab_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  // A reversal is checked before qualification, so a change undone on the
  // sample that would have qualified it is still rejected.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      S_LOW: begin
        if (sync_in) begin
          state_d = S_QUAL_H;
          stab_d  = 8'd1;
        end
      end
      S_QUAL_H: begin
        if (!sync_in) begin
          state_d = S_LOW;
          stab_d  = 8'd0;
        end else if (stab_q == QualCnt) begin
          state_d = S_HIGH;
          stab_d  = 8'd0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          state_d = S_QUAL_L;
          stab_d  = 8'd1;
        end
      end
      S_QUAL_L: begin
        if (sync_in) begin
          state_d = S_HIGH;
          stab_d  = 8'd0;
        end else if (stab_q == QualCnt) begin
          state_d = S_LOW;
          stab_d  = 8'd0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          stab_d = stab_q + 8'd1;
        end
      end
      default: begin
        state_d = S_LOW;
        stab_d  = 8'd0;
        level_d = 1'b0;
      end
    endcase
  end

  // A clear coinciding with a qualified rise keeps that rise as the first event.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (cnt_clr) begin
      cnt_d = rise_d ? CNT_W'(1) : '0;
      sat_d = 1'b0;
    end else if (rise_d) begin
      if (cnt_q == CntMax) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_dest or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      stab_q  <= 8'd0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign event_cnt  = cnt_q;
  assign cnt_sat    = sat_q;

endmodule

// File: tb/tb_sync_edge_qualifier.sv
// Directed bench: one default instance for filtering/latency, one CNT_W=2 instance
// for counter saturation and clear behaviour.
module tb_sync_edge_qualifier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       syncA = 1'b0;
  logic       rstAN = 1'b1;
  logic       clrA  = 1'b0;
  logic       levelA, riseA, fallA, satA;
  logic [7:0] cntA;

  logic       syncB = 1'b0;
  logic       rstBN = 1'b1;
  logic       clrB  = 1'b0;
  logic       levelB, riseB, fallB, satB;
  logic [1:0] cntB;

  int checkCount = 0;
  int errorCount = 0;

  sync_edge_qualifier dutA (
    .clk_dest  (clk),
    .rst_n     (rstAN),
    .sync_in   (syncA),
    .cnt_clr   (clrA),
    .level_out (levelA),
    .rise_pulse(riseA),
    .fall_pulse(fallA),
    .event_cnt (cntA),
    .cnt_sat   (satA)
  );

  sync_edge_qualifier #(.STABLE_CYCLES(4), .CNT_W(2)) dutB (
    .clk_dest  (clk),
    .rst_n     (rstBN),
    .sync_in   (syncB),
    .cnt_clr   (clrB),
    .level_out (levelB),
    .rise_pulse(riseB),
    .fall_pulse(fallB),
    .event_cnt (cntB),
    .cnt_sat   (satB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Each step ends 1 ns after a rising edge, where outputs are sampled and inputs driven.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic value, input int edges);
    syncA = value;
    step(edges);
  endtask

  task automatic checkAllZeroA(input string tag);
    checkOutput({tag, "_level"}, 32'(levelA), 0);
    checkOutput({tag, "_rise"},  32'(riseA),  0);
    checkOutput({tag, "_fall"},  32'(fallA),  0);
    checkOutput({tag, "_cnt"},   32'(cntA),   0);
    checkOutput({tag, "_sat"},   32'(satA),   0);
  endtask

  // Full rise/fall cycle on instance B; counter state is checked on the rise edge.
  task automatic riseCycleB(input string tag, input logic clr, input int expCnt, input int expSat);
    syncB = 1'b1;
    step(3);
    clrB = clr;
    step(1);
    clrB = 1'b0;
    checkOutput({tag, "_rise"}, 32'(riseB), 1);
    checkOutput({tag, "_cnt"},  32'(cntB),  32'(expCnt));
    checkOutput({tag, "_sat"},  32'(satB),  32'(expSat));
    syncB = 1'b0;
    step(5);
  endtask

  logic glitchSeq [9];

  initial begin
    glitchSeq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    #2;
    rstAN = 1'b0;
    rstBN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      syncA = ~syncA;
      step(1);
      checkAllZeroA("resetHold");
    end
    syncA = 1'b0;
    #2;
    rstAN = 1'b1;
    rstBN = 1'b1;
    step(3);
    checkAllZeroA("resetRelease");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(glitchSeq[i], 1);
      checkOutput("glitchRise",  32'(riseA),  0);
      checkOutput("glitchLevel", 32'(levelA), 0);
    end
    applyStimulus(1'b0, 3);
    checkOutput("glitchCnt", 32'(cntA), 0);

    applyStimulus(1'b1, 3);
    checkOutput("cleanPreRise", 32'(riseA),  0);
    checkOutput("cleanPreLvl",  32'(levelA), 0);
    step(1);
    checkOutput("cleanRise",    32'(riseA),  1);
    checkOutput("cleanLevel",   32'(levelA), 1);
    checkOutput("cleanCnt",     32'(cntA),   1);
    step(1);
    checkOutput("cleanRiseEnd", 32'(riseA),  0);
    checkOutput("cleanHold",    32'(levelA), 1);
    step(5);
    applyStimulus(1'b0, 3);
    checkOutput("cleanPreFall", 32'(fallA),  0);
    checkOutput("cleanPreLvl0", 32'(levelA), 1);
    step(1);
    checkOutput("cleanFall",    32'(fallA),  1);
    checkOutput("cleanFallRs",  32'(riseA),  0);
    checkOutput("cleanLevel0",  32'(levelA), 0);
    checkOutput("cleanCntHold", 32'(cntA),   1);
    step(1);
    checkOutput("cleanFallEnd", 32'(fallA),  0);

    applyStimulus(1'b1, 5);
    checkOutput("lowGlitchSetup", 32'(levelA), 1);
    checkOutput("lowGlitchCnt",   32'(cntA),   2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1);
      checkOutput("lowGlitchFall", 32'(fallA), 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1);
      checkOutput("lowGlitchFall2", 32'(fallA),  0);
      checkOutput("lowGlitchLevel", 32'(levelA), 1);
    end
    applyStimulus(1'b0, 6);
    checkOutput("lowAgain", 32'(levelA), 0);

    applyStimulus(1'b1, 2);
    rstAN = 1'b0;
    #1;
    checkAllZeroA("midReset");
    step(1);
    checkAllZeroA("midResetHeld");
    #2;
    rstAN = 1'b1;
    step(3);
    checkOutput("postResetEarly", 32'(riseA), 0);
    step(1);
    checkOutput("postResetRise",  32'(riseA),  1);
    checkOutput("postResetLevel", 32'(levelA), 1);
    checkOutput("postResetCnt",   32'(cntA),   1);

    riseCycleB("satRise1", 1'b0, 1, 0);
    riseCycleB("satRise2", 1'b0, 2, 0);
    riseCycleB("satRise3", 1'b0, 3, 0);
    riseCycleB("satRise4", 1'b0, 3, 1);
    riseCycleB("satRise5", 1'b0, 3, 1);
    clrB = 1'b1;
    step(1);
    clrB = 1'b0;
    checkOutput("clrAloneCnt", 32'(cntB), 0);
    checkOutput("clrAloneSat", 32'(satB), 0);
    riseCycleB("resat1", 1'b0, 1, 0);
    riseCycleB("resat2", 1'b0, 2, 0);
    riseCycleB("resat3", 1'b0, 3, 0);
    riseCycleB("resat4", 1'b0, 3, 1);
    riseCycleB("clrWithRise", 1'b1, 1, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
